pdp_fetch_responder: RTL and testbench
======================================

// Module: pdp_fetch_responder
// PURPOSE
// - Memory-side responder for PDP-11 instruction fetches. It serves the CPU's
//   fetch requests from a word-organised flash array over a req/ready +
//   valid/ack handshake.
// - Has a separate load port so a bench or boot loader can write program words.
// - Sits between the pdp_isa fetch stage and the flash storage.
// PARAMETERS
// - DEPTH        2048  flash size in 16-bit words; word index = fetch_addr[15:1]
// - WAIT_STATES  2     extra cycles between request accept and response (0..15)
// PORTS
// - clock        in   1   single clock; all logic on posedge
// - reset_n      in   1   asynchronous, active-low reset
// - fetch_req    in   1   CPU requests a word; fetch_addr stable while high
// - fetch_addr   in   16  byte address of the instruction word
// - fetch_ready  out  1   responder can accept a request this cycle
// - fetch_valid  out  1   fetch_data/fetch_err valid; held until fetch_ack
// - fetch_data   out  16  instruction word (0 when fetch_err)
// - fetch_err    out  1   odd address, or word index >= DEPTH
// - fetch_ack    in   1   CPU consumes the response
// - load_we      in   1   write strobe for the flash load port
// - load_addr    in   16  load word index (not a byte address)
// - load_data    in   16  word to write
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, fetch_ready=1, fetch_valid=0,
//   fetch_data=0, fetch_err=0, wait counter=0, prefetch buffer invalid.
//   Flash contents are not cleared.
// - FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: fetch_ready=1. Accept when fetch_req && fetch_ready; latch the
//     address. Go to WAIT if WAIT_STATES>0, else go to RESP.
//   - WAIT: fetch_ready=0. Count WAIT_STATES cycles. On the last count, read
//     flash, register data/err, and go to RESP.
//   - RESP: fetch_valid=1; data/err are stable. On fetch_ack, go to IDLE and
//     drop fetch_valid the next cycle. No new request is accepted in the ack
//     cycle; back-to-back requests are accepted the cycle after.
// - Latency: request accepted at edge N -> fetch_valid high after edge
//   N+WAIT_STATES+1.
// - Error: fetch_addr[0]=1, or fetch_addr[15:1] >= DEPTH, gives fetch_err=1 and
//   fetch_data=0 with the same latency. The flash is not accessed.
// - Read/write collision: a load_we to the word being read in the same cycle
//   returns the old data (read-before-write). The write still commits.
// - load_we with load_addr >= DEPTH is ignored. Loads are allowed in any state.
// - fetch_ack while fetch_valid=0 is ignored.
// - fetch_req dropping while in WAIT does not abort the fetch; the response is
//   still delivered.
// - reset_n asserted mid-fetch returns to IDLE at once; the response is lost.
// - Address wrap: no incrementing inside this block except the prefetch
//   address. 16'hFFFE+2 wraps to 16'h0000 (error if out of range).
// CONFIGURATION
// - PDP_FETCH_PREFETCH_EN defined:
//   - After each non-error response, the block reads word addr+2 into a
//     one-entry buffer. This takes WAIT_STATES cycles in the background and
//     fetch_ready stays 1 during it.
//   - Hit (same address, buffer valid): fetch_valid one cycle after accept.
//   - Miss: normal path. An in-flight background prefetch is abandoned.
//   - A load_we to the buffered word index invalidates the buffer.
// - PDP_FETCH_PREFETCH_EN undefined: no buffer; every fetch costs
//   WAIT_STATES+1 cycles.
// TESTING
// - Reset, then flash[0]=16'h18C0, fetch addr 0, WAIT_STATES=2 -> valid 3
//   cycles after accept, data 16'h18C0, err=0.
// - Fetch addr 16'h0003 -> fetch_err=1, fetch_data=0, same latency; then
//   addr 16'h1000 (index 2048) -> fetch_err=1.
// - Hold fetch_ack low 5 cycles -> valid and data stable, fetch_ready=0
//   throughout; ack -> ready=1 the next cycle.
// - load_we to index 4 with data 16'hAAAA in the read cycle of addr 8
//   (old 16'h5555) -> response 16'h5555; refetch -> 16'hAAAA.
// - Assert reset_n=0 in WAIT -> fetch_valid=0 and fetch_ready=1 immediately;
//   the next fetch completes normally.
// - With PDP_FETCH_PREFETCH_EN: fetch 0 then 2 -> second valid 1 cycle after
//   accept. A load to index 1 between them -> miss, normal latency, new data.

Source files
------------

// File: rtl/pdp_fetch_responder.sv
// Flash-backed instruction fetch responder: a response is valid WAIT_STATES+1 cycles after accept, and stays held until fetch_ack_i; one request is in flight at a time.
// Optional one-word prefetch buffer: `define PDP_FETCH_PREFETCH_EN (a hit is valid 1 cycle after accept).
module pdp_fetch_responder #(
   parameter int unsigned DEPTH       = 2048,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        fetch_req_i,
   input  logic [15:0] fetch_addr_i,
   output logic        fetch_ready_o,
   output logic        fetch_valid_o,
   output logic [15:0] fetch_data_o,
   output logic        fetch_err_o,
   input  logic        fetch_ack_i,
   input  logic        load_we_i,
   input  logic [15:0] load_addr_i,
   input  logic [15:0] load_data_i
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   logic [15:0] mem [DEPTH];

   state_t      state_q;
   logic        ready_q;
   logic        valid_q;
   logic [15:0] data_q;
   logic        err_q;
   logic [3:0]  cnt_q;
   logic [15:0] addr_q;

   logic        acc_bad_d;
   logic        lat_bad_d;
   logic        load_ok_d;
   logic        accept_d;
   logic [15:0] acc_rd_d;
   logic [15:0] lat_rd_d;

   assign acc_bad_d = fetch_addr_i[0] || (32'(fetch_addr_i[15:1]) >= DEPTH);
   assign lat_bad_d = addr_q[0] || (32'(addr_q[15:1]) >= DEPTH);
   assign load_ok_d = load_we_i && (32'(load_addr_i) < DEPTH);
   assign accept_d  = fetch_req_i && ready_q;
   assign acc_rd_d  = mem[fetch_addr_i[AW:1]];
   assign lat_rd_d  = mem[addr_q[AW:1]];

`ifdef PDP_FETCH_PREFETCH_EN
   logic        pf_busy_q;
   logic        pf_vld_q;
   logic [3:0]  pf_cnt_q;
   logic [15:0] pf_addr_q;
   logic [15:0] pf_data_q;

   logic [15:0] nxt_addr_d;
   logic        nxt_bad_d;
   logic        pf_hit_d;
   logic        pf_load_hit_d;
   logic [15:0] pf_rd_d;

   assign nxt_addr_d    = addr_q + 16'd2;
   assign nxt_bad_d     = nxt_addr_d[0] || (32'(nxt_addr_d[15:1]) >= DEPTH);
   assign pf_hit_d      = pf_vld_q && (fetch_addr_i == pf_addr_q);
   assign pf_load_hit_d = load_ok_d && (load_addr_i == {1'b0, pf_addr_q[15:1]});
   assign pf_rd_d       = mem[pf_addr_q[AW:1]];
`endif

   // Flash array has no reset: program contents survive reset_n.
   always_ff @(posedge clock_i) begin
      if (load_ok_d) begin
         mem[load_addr_i[AW-1:0]] <= load_data_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         data_q    <= 16'h0000;
         err_q     <= 1'b0;
         cnt_q     <= 4'd0;
         addr_q    <= 16'h0000;
`ifdef PDP_FETCH_PREFETCH_EN
         pf_busy_q <= 1'b0;
         pf_vld_q  <= 1'b0;
         pf_cnt_q  <= 4'd0;
         pf_addr_q <= 16'h0000;
         pf_data_q <= 16'h0000;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
`ifdef PDP_FETCH_PREFETCH_EN
               if (pf_busy_q) begin
                  if (pf_cnt_q == LAST_CNT) begin
                     pf_data_q <= pf_rd_d;
                     pf_vld_q  <= 1'b1;
                     pf_busy_q <= 1'b0;
                  end else begin
                     pf_cnt_q <= pf_cnt_q + 4'd1;
                  end
               end
`endif
               if (accept_d) begin
                  addr_q  <= fetch_addr_i;
                  ready_q <= 1'b0;
                  cnt_q   <= 4'd0;
`ifdef PDP_FETCH_PREFETCH_EN
                  // Any accept consumes or abandons the buffer.
                  pf_busy_q <= 1'b0;
                  pf_vld_q  <= 1'b0;
                  if (pf_hit_d) begin
                     data_q  <= pf_data_q;
                     err_q   <= 1'b0;
                     state_q <= S_RESP;
                  end else
`endif
                  if (WAIT_STATES == 0) begin
                     data_q  <= acc_bad_d ? 16'h0000 : acc_rd_d;
                     err_q   <= acc_bad_d;
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Read at the final wait edge; a same-edge load commits after this read.
               if (cnt_q == LAST_CNT) begin
                  data_q  <= lat_bad_d ? 16'h0000 : lat_rd_d;
                  err_q   <= lat_bad_d;
                  cnt_q   <= 4'd0;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_RESP: begin
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (fetch_ack_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
`ifdef PDP_FETCH_PREFETCH_EN
                  if (!err_q) begin
                     pf_addr_q <= nxt_addr_d;
                     pf_busy_q <= !nxt_bad_d;
                     pf_cnt_q  <= 4'd0;
                     pf_vld_q  <= 1'b0;
                  end
`endif
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
`ifdef PDP_FETCH_PREFETCH_EN
         if (pf_load_hit_d) begin
            pf_vld_q <= 1'b0;
         end
`endif
      end
   end

   assign fetch_ready_o = ready_q;
   assign fetch_valid_o = valid_q;
   assign fetch_data_o  = data_q;
   assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_pdp_fetch_responder.sv
// Directed bench for pdp_fetch_responder: scoreboard of expected responses, immediate-assert checks.
module tb_pdp_fetch_responder;

   logic        clock_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        fetch_req_i = 1'b0;
   logic [15:0] fetch_addr_i = 16'h0000;
   logic        fetch_ready_o;
   logic        fetch_valid_o;
   logic [15:0] fetch_data_o;
   logic        fetch_err_o;
   logic        fetch_ack_i = 1'b0;
   logic        load_we_i = 1'b0;
   logic [15:0] load_addr_i = 16'h0000;
   logic [15:0] load_data_i = 16'h0000;

   pdp_fetch_responder dut (
      .clock_i       (clock_i),
      .reset_n_i     (reset_n_i),
      .fetch_req_i   (fetch_req_i),
      .fetch_addr_i  (fetch_addr_i),
      .fetch_ready_o (fetch_ready_o),
      .fetch_valid_o (fetch_valid_o),
      .fetch_data_o  (fetch_data_o),
      .fetch_err_o   (fetch_err_o),
      .fetch_ack_i   (fetch_ack_i),
      .load_we_i     (load_we_i),
      .load_addr_i   (load_addr_i),
      .load_data_i   (load_data_i)
   );

   always #5 clock_i = ~clock_i;

   typedef struct packed {
      logic        err;
      logic [15:0] data;
   } exp_t;

   localparam int MISS_LAT = 3;
`ifdef PDP_FETCH_PREFETCH_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 3;
`endif

   exp_t        sb[$];
   logic [15:0] model [2048];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load(input logic [15:0] idx, input logic [15:0] d);
      load_we_i   = 1'b1;
      load_addr_i = idx;
      load_data_i = d;
      @(negedge clock_i);
      load_we_i = 1'b0;
      if (idx < 16'd2048) model[idx[10:0]] = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock_i);
   endtask

   // coll_at >= 0 drives a load during that post-accept cycle.
   task automatic fetch(input string tag, input logic [15:0] a, input int exp_lat, input int hold,
                        input int coll_at, input logic [15:0] coll_idx, input logic [15:0] coll_dat);
      exp_t e;
      exp_t got;
      int   n;
      int   lat;
      fetch_req_i  = 1'b1;
      fetch_addr_i = a;
      n = 0;
      while (fetch_ready_o !== 1'b1 && n < 20) begin
         @(negedge clock_i);
         n++;
      end
      check({tag, "_accept"}, 32'(fetch_ready_o), 32'd1);
      e.err  = a[0] || (a[15:1] >= 15'd2048);
      e.data = e.err ? 16'h0000 : model[a[11:1]];
      sb.push_back(e);
      @(negedge clock_i);
      fetch_req_i = 1'b0;
      lat = 0;
      while (fetch_valid_o !== 1'b1 && lat < 40) begin
         if (lat == coll_at) begin
            load_we_i   = 1'b1;
            load_addr_i = coll_idx;
            load_data_i = coll_dat;
         end
         @(negedge clock_i);
         if (load_we_i) begin
            load_we_i = 1'b0;
            if (coll_idx < 16'd2048) model[coll_idx[10:0]] = coll_dat;
         end
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, "_data"}, 32'(fetch_data_o), 32'(got.data));
         check({tag, "_err"}, 32'(fetch_err_o), 32'(got.err));
         for (int i = 0; i < hold; i++) begin
            @(negedge clock_i);
            check({tag, "_hold_valid"}, 32'(fetch_valid_o), 32'd1);
            check({tag, "_hold_data"}, 32'(fetch_data_o), 32'(got.data));
            check({tag, "_hold_ready"}, 32'(fetch_ready_o), 32'd0);
         end
      end
      fetch_ack_i = 1'b1;
      @(negedge clock_i);
      fetch_ack_i = 1'b0;
      check({tag, "_post_ack_valid"}, 32'(fetch_valid_o), 32'd0);
      check({tag, "_post_ack_ready"}, 32'(fetch_ready_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) model[i] = 16'h0000;
      idle(2);
      check("rst_ready", 32'(fetch_ready_o), 32'd1);
      check("rst_valid", 32'(fetch_valid_o), 32'd0);
      check("rst_data", 32'(fetch_data_o), 32'd0);
      check("rst_err", 32'(fetch_err_o), 32'd0);
      reset_n_i = 1'b1;
      idle(1);

      load(16'd0, 16'h18C0);
      load(16'd1, 16'h1234);
      load(16'd4, 16'h5555);
      load(16'd5, 16'h0BEE);

      fetch("f0", 16'h0000, MISS_LAT, 0, -1, 16'd0, 16'd0);
      idle(4);
      fetch("f2_seq", 16'h0002, HIT_LAT, 0, -1, 16'd0, 16'd0);
      fetch("odd", 16'h0003, MISS_LAT, 0, -1, 16'd0, 16'd0);
      fetch("oor", 16'h1000, MISS_LAT, 0, -1, 16'd0, 16'd0);
      fetch("hold", 16'h000A, MISS_LAT, 5, -1, 16'd0, 16'd0);
      fetch("collide", 16'h0008, MISS_LAT, 0, 1, 16'd4, 16'hAAAA);
      fetch("refetch", 16'h0008, MISS_LAT, 0, -1, 16'd0, 16'd0);

      fetch("f0_b", 16'h0000, MISS_LAT, 0, -1, 16'd0, 16'd0);
      idle(4);
      load(16'd1, 16'h4321);
      fetch("f2_inval", 16'h0002, MISS_LAT, 0, -1, 16'd0, 16'd0);

      // Reset while the fetch is waiting on flash.
      fetch_req_i  = 1'b1;
      fetch_addr_i = 16'h0000;
      @(negedge clock_i);
      fetch_req_i = 1'b0;
      reset_n_i   = 1'b0;
      #1;
      check("rst_wait_valid", 32'(fetch_valid_o), 32'd0);
      check("rst_wait_ready", 32'(fetch_ready_o), 32'd1);
      check("rst_wait_data", 32'(fetch_data_o), 32'd0);
      @(negedge clock_i);
      reset_n_i = 1'b1;
      idle(1);
      fetch("after_rst", 16'h0002, MISS_LAT, 0, -1, 16'd0, 16'd0);

      fetch_ack_i = 1'b1;
      @(negedge clock_i);
      fetch_ack_i = 1'b0;
      check("stray_ack_ready", 32'(fetch_ready_o), 32'd1);
      check("stray_ack_valid", 32'(fetch_valid_o), 32'd0);

      load(16'h0800, 16'hFFFF);
      fetch("oor_load", 16'h0000, MISS_LAT, 0, -1, 16'd0, 16'd0);
      fetch("wrap_top", 16'hFFFE, MISS_LAT, 0, -1, 16'd0, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
